// File: rtl/tcdm_burst_master.sv
// tcdm_burst_master: converts one linear job (base, word count, direction) into
// single-word requests on the TCDM crossbar master port. Read data comes back
// through a small FIFO as a valid/ready stream; write data is taken from a
// valid/ready stream.
// Optional feature macro: TCDM_BURST_ERR_EN (sticky response-error flag on err_o).
module tcdm_burst_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_write_i,
    input  logic [31:0]      cmd_addr_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic             wdata_valid_i,
    output logic             wdata_ready_o,
    input  logic [31:0]      wdata_i,
    output logic             rdata_valid_o,
    input  logic             rdata_ready_i,
    output logic [31:0]      rdata_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             tcdm_req_o,
    output logic [31:0]      tcdm_add_o,
    output logic             tcdm_wen_o,
    output logic [31:0]      tcdm_wdata_o,
    output logic [3:0]       tcdm_be_o,
    input  logic             tcdm_gnt_i,
    input  logic             tcdm_r_valid_i,
    input  logic             tcdm_r_opc_i,
    input  logic [31:0]      tcdm_r_rdata_i
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               write_q;
    logic [31:0]        base_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   idx_q;
    logic [CNT_W-1:0]   outstanding_q;
    logic [CNT_W-1:0]   fifo_count_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [31:0]        fifo_mem [FIFO_DEPTH];

    logic               cmd_hs;
    logic               xfer;
    logic               last_word;
    logic               read_job;
    logic               push;
    logic               pop;
    logic               room;
    logic [CNT_W:0]     in_use;

    assign cmd_hs    = cmd_valid_i & (state_q == IDLE);
    assign xfer      = tcdm_req_o & tcdm_gnt_i;
    assign last_word = (idx_q == (len_q - LEN_W'(1)));
    assign read_job  = (state_q != IDLE) & ~write_q;
    assign push      = tcdm_r_valid_i & read_job;
    assign pop       = (fifo_count_q != '0) & rdata_ready_i;

    // Reads already in flight plus words parked in the FIFO may never exceed the FIFO size.
    assign in_use = {1'b0, outstanding_q} + {1'b0, fifo_count_q};
    assign room   = in_use < (CNT_W + 1)'(FIFO_DEPTH);

    assign cmd_ready_o   = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);
    assign rdata_valid_o = (fifo_count_q != '0);
    assign rdata_o       = (fifo_count_q != '0) ? fifo_mem[rd_ptr_q] : 32'h0;

    // Next-state logic and the request channel; request is dropped while reset is asserted.
    always_comb begin
        state_d       = state_q;
        tcdm_req_o    = 1'b0;
        tcdm_add_o    = 32'h0;
        tcdm_wen_o    = 1'b1;
        tcdm_wdata_o  = 32'h0;
        tcdm_be_o     = 4'h0;
        wdata_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    state_d = (cmd_len_i == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                tcdm_add_o = base_q + (32'(idx_q) << 2);
                tcdm_be_o  = 4'hF;
                if (write_q) begin
                    tcdm_wen_o    = 1'b0;
                    tcdm_wdata_o  = wdata_i;
                    tcdm_req_o    = wdata_valid_i & ~rst_i;
                    wdata_ready_o = wdata_valid_i & ~rst_i & tcdm_gnt_i;
                end else begin
                    tcdm_req_o = room & ~rst_i;
                end
                if (tcdm_req_o && tcdm_gnt_i && last_word) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((outstanding_q == '0) && (fifo_count_q == '0)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the job on handshake and advance the word index on every granted request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            write_q <= 1'b0;
            base_q  <= 32'h0;
            len_q   <= '0;
            idx_q   <= '0;
        end else if (cmd_hs) begin
            write_q <= cmd_write_i;
            base_q  <= cmd_addr_i;
            len_q   <= cmd_len_i;
            idx_q   <= '0;
        end else if (xfer && !last_word) begin
            idx_q   <= idx_q + LEN_W'(1);
        end
    end

    // Track granted reads whose response has not yet arrived.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding_q <= '0;
        end else begin
            case ({xfer & ~write_q, push})
                2'b10:   outstanding_q <= outstanding_q + CNT_W'(1);
                2'b01:   outstanding_q <= outstanding_q - CNT_W'(1);
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    // Read-data FIFO pointers and occupancy; push and pop may happen together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count_q <= fifo_count_q + CNT_W'(1);
                2'b01:   fifo_count_q <= fifo_count_q - CNT_W'(1);
                default: fifo_count_q <= fifo_count_q;
            endcase
        end
    end

    // FIFO storage; contents are qualified by the occupancy count so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= tcdm_r_rdata_i;
        end
    end

`ifdef TCDM_BURST_ERR_EN
    logic err_q;

    // Sticky error from a read response with r_opc set; cleared by the next job.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (cmd_hs) begin
            err_q <= 1'b0;
        end else if (push && tcdm_r_opc_i) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    logic unused_r_opc;

    assign unused_r_opc = tcdm_r_opc_i;
    assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_tcdm_burst_master.sv
// tb_tcdm_burst_master: directed bench for tcdm_burst_master with a built-in
// TCDM slave that answers each granted read one cycle later.
// Honours TCDM_BURST_ERR_EN the same way the design does.
module tb_tcdm_burst_master;

    localparam logic [31:0] MAGIC = 32'hA5A5_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_write_i = 1'b0;
    logic [31:0] cmd_addr_i = 32'h0;
    logic [15:0] cmd_len_i = 16'h0;
    logic        wdata_valid_i = 1'b0;
    logic        wdata_ready_o;
    logic [31:0] wdata_i = 32'h0;
    logic        rdata_valid_o;
    logic        rdata_ready_i = 1'b1;
    logic [31:0] rdata_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        tcdm_req_o;
    logic [31:0] tcdm_add_o;
    logic        tcdm_wen_o;
    logic [31:0] tcdm_wdata_o;
    logic [3:0]  tcdm_be_o;
    logic        tcdm_gnt_i = 1'b0;
    logic        tcdm_r_valid_i = 1'b0;
    logic        tcdm_r_opc_i = 1'b0;
    logic [31:0] tcdm_r_rdata_i = 32'h0;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          wr_ready_cnt = 0;
    int          viol = 0;
    logic        err_seen = 1'b0;
    logic        opc_en = 1'b0;
    logic [31:0] opc_addr = 32'h0;
    logic [31:0] grant_adds[$];
    int          grant_cyc[$];
    logic [31:0] wr_data[$];
    logic [3:0]  wr_be[$];
    logic [31:0] popped[$];

    tcdm_burst_master #(.FIFO_DEPTH(4), .LEN_W(16)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_write_i    (cmd_write_i),
        .cmd_addr_i     (cmd_addr_i),
        .cmd_len_i      (cmd_len_i),
        .wdata_valid_i  (wdata_valid_i),
        .wdata_ready_o  (wdata_ready_o),
        .wdata_i        (wdata_i),
        .rdata_valid_o  (rdata_valid_o),
        .rdata_ready_i  (rdata_ready_i),
        .rdata_o        (rdata_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o),
        .tcdm_req_o     (tcdm_req_o),
        .tcdm_add_o     (tcdm_add_o),
        .tcdm_wen_o     (tcdm_wen_o),
        .tcdm_wdata_o   (tcdm_wdata_o),
        .tcdm_be_o      (tcdm_be_o),
        .tcdm_gnt_i     (tcdm_gnt_i),
        .tcdm_r_valid_i (tcdm_r_valid_i),
        .tcdm_r_opc_i   (tcdm_r_opc_i),
        .tcdm_r_rdata_i (tcdm_r_rdata_i)
    );

    // Free-running 10 ns clock.
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle: log what happens before the edge, then play the TCDM slave.
    task automatic tick();
        logic        fire;
        logic [31:0] a;
        #1;
        if (tcdm_req_o && tcdm_gnt_i) begin
            grant_adds.push_back(tcdm_add_o);
            grant_cyc.push_back(cyc);
            if (!tcdm_wen_o) begin
                wr_data.push_back(tcdm_wdata_o);
                wr_be.push_back(tcdm_be_o);
            end
        end
        if (wdata_ready_o) wr_ready_cnt++;
        if (tcdm_req_o && !tcdm_wen_o && !wdata_valid_i) viol++;
        if (rdata_valid_o && rdata_ready_i) popped.push_back(rdata_o);
        if (done_o) done_cnt++;
        if (err_o) err_seen = 1'b1;
        fire = tcdm_req_o & tcdm_gnt_i & tcdm_wen_o;
        a    = tcdm_add_o;
        @(posedge clk_i);
        #1;
        cyc++;
        tcdm_r_valid_i = fire;
        tcdm_r_rdata_i = fire ? (a ^ MAGIC) : 32'h0;
        tcdm_r_opc_i   = fire & opc_en & (a == opc_addr);
        #2;
    endtask

    task automatic clearLog();
        grant_adds.delete();
        grant_cyc.delete();
        wr_data.delete();
        wr_be.delete();
        popped.delete();
        done_cnt     = 0;
        wr_ready_cnt = 0;
        viol         = 0;
    endtask

    // Present one job for a single handshake cycle.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [15:0] len);
        clearLog();
        cmd_valid_i = 1'b1;
        cmd_write_i = wr;
        cmd_addr_i  = addr;
        cmd_len_i   = len;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic runUntilDone(input string tag, input int maxc);
        int n = 0;
        while (done_cnt == 0 && n < maxc) begin
            tick();
            n++;
        end
        checkOutput({tag, "_done_seen"}, done_cnt, 1);
    endtask

    task automatic checkGrants(input string tag, input logic [31:0] base, input int n);
        checkOutput({tag, "_grant_count"}, grant_adds.size(), n);
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_add%0d", tag, i),
                        (i < grant_adds.size()) ? grant_adds[i] : 32'hDEAD_BEEF,
                        base + 32'(4 * i));
        end
    endtask

    task automatic checkPopped(input string tag, input logic [31:0] base, input int n);
        checkOutput({tag, "_word_count"}, popped.size(), n);
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_word%0d", tag, i),
                        (i < popped.size()) ? popped[i] : 32'hDEAD_BEEF,
                        (base + 32'(4 * i)) ^ MAGIC);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_cmd_ready"}, cmd_ready_o, 1);
        checkOutput({tag, "_busy"}, busy_o, 0);
        checkOutput({tag, "_done"}, done_o, 0);
        checkOutput({tag, "_req"}, tcdm_req_o, 0);
        checkOutput({tag, "_wen"}, tcdm_wen_o, 1);
        checkOutput({tag, "_add"}, tcdm_add_o, 0);
        checkOutput({tag, "_rvalid"}, rdata_valid_o, 0);
        checkOutput({tag, "_wready"}, wdata_ready_o, 0);
        checkOutput({tag, "_err"}, err_o, 0);
    endtask

    // Directed sequence of jobs.
    initial begin
        $display("[TB] start");

        // Reset state.
        rst_i = 1'b1;
        repeat (2) tick();
        rst_i = 1'b0;
        #1;
        checkResetOutputs("reset");

        // Read 4 words at 0x100 with an always-granting slave.
        tcdm_gnt_i    = 1'b1;
        rdata_ready_i = 1'b1;
        applyStimulus(1'b0, 32'h100, 16'd4);
        #1;
        checkOutput("rd4_req_first", tcdm_req_o, 1);
        checkOutput("rd4_wen_first", tcdm_wen_o, 1);
        checkOutput("rd4_cmd_ready_busy", cmd_ready_o, 0);
        runUntilDone("rd4", 30);
        tick();
        #1;
        checkOutput("rd4_busy_after", busy_o, 0);
        checkOutput("rd4_done_pulses", done_cnt, 1);
        checkGrants("rd4", 32'h100, 4);
        checkOutput("rd4_back_to_back", (grant_cyc.size() == 4) ? (grant_cyc[3] - grant_cyc[0]) : -1, 3);
        checkPopped("rd4", 32'h100, 4);

        // Write 3 words at 0x200 with wdata_valid toggling every cycle.
        applyStimulus(1'b1, 32'h200, 16'd3);
        for (int n = 0; n < 30 && done_cnt == 0; n++) begin
            wdata_valid_i = ((cyc % 2) == 1);
            wdata_i       = 32'hD000_0000 + 32'(wr_data.size());
            #1;
            if (tcdm_req_o) begin
                checkOutput("wr_wen_low", tcdm_wen_o, 0);
                checkOutput("wr_be", tcdm_be_o, 4'hF);
            end
            tick();
        end
        wdata_valid_i = 1'b0;
        checkOutput("wr_done_pulses", done_cnt, 1);
        checkOutput("wr_req_without_valid", viol, 0);
        checkOutput("wr_ready_pulses", wr_ready_cnt, 3);
        checkGrants("wr", 32'h200, 3);
        checkOutput("wr_data_count", wr_data.size(), 3);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("wr_data%0d", i),
                        (i < wr_data.size()) ? wr_data[i] : 32'hDEAD_BEEF,
                        32'hD000_0000 + 32'(i));
            checkOutput($sformatf("wr_be%0d", i),
                        (i < wr_be.size()) ? 32'(wr_be[i]) : 32'h0, 32'hF);
        end

        // Read 8 words with the stream stalled: only FIFO_DEPTH reads may be issued.
        rdata_ready_i = 1'b0;
        applyStimulus(1'b0, 32'h300, 16'd8);
        repeat (12) tick();
        #1;
        checkOutput("rd8_stall_grants", grant_adds.size(), 4);
        checkOutput("rd8_stall_req", tcdm_req_o, 0);
        checkOutput("rd8_stall_rvalid", rdata_valid_o, 1);
        checkOutput("rd8_stall_head", rdata_o, 32'h300 ^ MAGIC);
        rdata_ready_i = 1'b1;
        runUntilDone("rd8", 60);
        checkGrants("rd8", 32'h300, 8);
        checkPopped("rd8", 32'h300, 8);

        // Grant withheld for 5 cycles: request must hold steady.
        tcdm_gnt_i = 1'b0;
        applyStimulus(1'b0, 32'h400, 16'd2);
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput($sformatf("hold_req%0d", i), tcdm_req_o, 1);
            checkOutput($sformatf("hold_add%0d", i), tcdm_add_o, 32'h400);
            checkOutput($sformatf("hold_wen%0d", i), tcdm_wen_o, 1);
            tick();
        end
        checkOutput("hold_no_grant", grant_adds.size(), 0);
        tcdm_gnt_i = 1'b1;
        runUntilDone("hold", 30);
        checkGrants("hold", 32'h400, 2);
        checkPopped("hold", 32'h400, 2);

        // Zero-length job: no request, done on the cycle after the handshake cycle.
        applyStimulus(1'b0, 32'h700, 16'd0);
        #1;
        checkOutput("len0_done", done_o, 1);
        checkOutput("len0_req", tcdm_req_o, 0);
        tick();
        #1;
        checkOutput("len0_done_low", done_o, 0);
        checkOutput("len0_busy", busy_o, 0);
        checkOutput("len0_pulses", done_cnt, 1);
        checkOutput("len0_grants", grant_adds.size(), 0);

        // Address wrap-around at the top of the address space.
        applyStimulus(1'b0, 32'hFFFF_FFFC, 16'd2);
        runUntilDone("wrap", 30);
        checkGrants("wrap", 32'hFFFF_FFFC, 2);
        checkPopped("wrap", 32'hFFFF_FFFC, 2);

        // Error response on word 2 of a read.
        err_seen = 1'b0;
        opc_en   = 1'b1;
        opc_addr = 32'h508;
        applyStimulus(1'b0, 32'h500, 16'd4);
        runUntilDone("err", 30);
        opc_en = 1'b0;
        tick();
        #1;
`ifdef TCDM_BURST_ERR_EN
        checkOutput("err_sticky", err_o, 1);
`else
        checkOutput("err_tied_low", err_o, 0);
        checkOutput("err_never_seen", err_seen, 0);
`endif
        checkPopped("err", 32'h500, 4);

        // Reset in the middle of a stalled read job.
        rdata_ready_i = 1'b0;
        applyStimulus(1'b0, 32'h600, 16'd8);
`ifdef TCDM_BURST_ERR_EN
        #1;
        checkOutput("err_cleared_by_cmd", err_o, 0);
`endif
        repeat (3) tick();
        #1;
        checkOutput("midrst_busy_before", busy_o, 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        checkResetOutputs("midrst");
        tick();
        #1;
        checkOutput("midrst_rvalid_later", rdata_valid_o, 0);
        checkOutput("midrst_busy_later", busy_o, 0);
        rdata_ready_i = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
